// File: rtl/rvfi_imem_resp.sv
// rtl/rvfi_imem_resp.sv - fetch responder returning the constrained imem halfword after a fixed latency
// Optional fetch-fault side-band is enabled by defining RVFI_IMEM_RESP_ERR_EN.
module rvfi_imem_resp #(
   parameter int XLEN    = 32,
   parameter int LATENCY = 1,
   parameter int DEPTH   = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [XLEN-1:0] req_addr,
`ifdef RVFI_IMEM_RESP_ERR_EN
   input  logic            fill_err,
   output logic            resp_err,
`endif
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic [31:0]     resp_data,
   input  logic [XLEN-1:0] imem_addr,
   input  logic [15:0]     imem_data,
   input  logic [31:0]     fill_data
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int AW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   logic [31:0]     data_mem [DEPTH];
   logic [AW-1:0]   age      [DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [CW-1:0]   count;
   logic            push;
   logic            pop;
   logic [XLEN-1:0] word_addr;
   logic [XLEN-1:0] word_addr_hi;
   logic [XLEN-1:0] chk_addr;
   logic            hit_lo;
   logic            hit_hi;
   logic [31:0]     word;

   // Masking keeps every address bit read while ignoring the sub-word offsets.
   assign word_addr    = req_addr & ~XLEN'(3);
   assign word_addr_hi = word_addr + XLEN'(2);
   assign chk_addr     = imem_addr & ~XLEN'(1);
   assign hit_lo       = (chk_addr == word_addr);
   assign hit_hi       = (chk_addr == word_addr_hi);
   assign word         = {hit_hi ? imem_data : fill_data[31:16],
                          hit_lo ? imem_data : fill_data[15:0]};

   assign req_ready  = (count < CW'(DEPTH));
   assign push       = req_valid && req_ready;
   assign resp_valid = (count != '0) && (age[rd_ptr] == '0);
   assign pop        = resp_valid && resp_ready;
   assign resp_data  = data_mem[rd_ptr];

   // Age counters run per slot so queued entries mature while waiting behind the head.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            data_mem[i] <= '0;
            age[i]      <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (age[i] != '0)
               age[i] <= age[i] - AW'(1);
         end
         if (push) begin
            data_mem[wr_ptr] <= word;
            age[wr_ptr]      <= AW'(LATENCY - 1);
            wr_ptr           <= wr_ptr + PW'(1);
         end
         if (pop)
            rd_ptr <= rd_ptr + PW'(1);
         if (push && !pop)
            count <= count + CW'(1);
         else if (pop && !push)
            count <= count - CW'(1);
      end
   end

`ifdef RVFI_IMEM_RESP_ERR_EN
   logic err_mem [DEPTH];

   // A fetch that covers the checked halfword is never reported as faulting.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++)
            err_mem[i] <= 1'b0;
      end else if (push) begin
         err_mem[wr_ptr] <= fill_err && !(hit_lo || hit_hi);
      end
   end

   assign resp_err = resp_valid && err_mem[rd_ptr];
`endif

endmodule

// File: tb/tb_rvfi_imem_resp.sv
// tb/tb_rvfi_imem_resp.sv - scoreboard bench for rvfi_imem_resp with a behavioural fetch model
// Build with RVFI_IMEM_RESP_ERR_EN defined to also cover the fault side-band.
module tb_rvfi_imem_resp;

   localparam int XLEN    = 32;
   localparam int LATENCY = 2;
   localparam int DEPTH   = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_data;
   logic [31:0] imem_addr;
   logic [15:0] imem_data;
   logic [31:0] fill_data;
`ifdef RVFI_IMEM_RESP_ERR_EN
   logic        fill_err;
   logic        resp_err;
`endif

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      logic [31:0] data;
      logic        err;
      int          acc;
   } exp_t;

   exp_t exp_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   rvfi_imem_resp #(.XLEN(XLEN), .LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_addr   (req_addr),
`ifdef RVFI_IMEM_RESP_ERR_EN
      .fill_err   (fill_err),
      .resp_err   (resp_err),
`endif
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .imem_addr  (imem_addr),
      .imem_data  (imem_data),
      .fill_data  (fill_data)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Fetch word as seen by the core: checked halfword wherever it lies, fill elsewhere.
   function automatic exp_t model(input logic [31:0] ra, input logic [31:0] ia,
                                  input logic [15:0] id, input logic [31:0] fd,
                                  input logic fe, input int acc);
      exp_t e;
      logic [31:0] a;
      logic [31:0] m;
      a = ra - (ra % 4);
      m = ia - (ia % 2);
      e.data[15:0]  = (m == a)      ? id : fd[15:0];
      e.data[31:16] = (m == a + 32'd2) ? id : fd[31:16];
      e.err = fe && (m != a) && (m != a + 32'd2);
      e.acc = acc;
      return e;
   endfunction

   // Stimulus side: record each request that the next edge will accept.
   always @(negedge clk) begin
      logic fe;
      #2;
      fe = 1'b0;
`ifdef RVFI_IMEM_RESP_ERR_EN
      fe = fill_err;
`endif
      if (reset)
         exp_q.delete();
      else if (req_valid && req_ready)
         exp_q.push_back(model(req_addr, imem_addr, imem_data, fill_data, fe, cyc + 1));
   end

   // Monitor: occupancy, maturity, ordering and stall stability against the queue.
   logic        held = 1'b0;
   logic [31:0] held_data;
   always @(negedge clk) begin
      logic exp_v;
      if (reset) begin
         held = 1'b0;
      end else begin
         exp_v = (exp_q.size() > 0) && (cyc >= exp_q[0].acc + LATENCY - 1);
         chk("req_ready", 32'(req_ready), 32'(exp_q.size() < DEPTH));
         chk("resp_valid", 32'(resp_valid), 32'(exp_v));
         if (held && resp_valid)
            chk("stall_stable", resp_data, held_data);
         if (resp_valid && exp_v) begin
            chk("resp_data", resp_data, exp_q[0].data);
`ifdef RVFI_IMEM_RESP_ERR_EN
            chk("resp_err", 32'(resp_err), 32'(exp_q[0].err));
`endif
            if (resp_ready)
               void'(exp_q.pop_front());
         end
         held      = resp_valid && !resp_ready;
         held_data = resp_data;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input logic [31:0] addr);
      req_valid = 1'b1;
      req_addr  = addr;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (req_ready) begin
            step();
            req_valid = 1'b0;
            return;
         end
         step();
      end
      checks++;
      errors++;
      $display("FAIL req_timeout: addr %h never accepted", addr);
      req_valid = 1'b0;
   endtask

   task automatic drain();
      for (int k = 0; k < 100 && exp_q.size() > 0; k++)
         step();
      chk("drain_empty", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      logic [31:0] base;
      reset      = 1'b1;
      req_valid  = 1'b1;
      req_addr   = 32'h100;
      resp_ready = 1'b1;
      imem_addr  = 32'h100;
      imem_data  = 16'hABCD;
      fill_data  = 32'h1234_5678;
`ifdef RVFI_IMEM_RESP_ERR_EN
      fill_err   = 1'b0;
`endif
      // Two reset cycles with a request pending: nothing may be accepted.
      @(negedge clk);
      chk("rst_valid", 32'(resp_valid), 32'd0);
      chk("rst_ready", 32'(req_ready), 32'd1);
      chk("rst_data", resp_data, 32'd0);
      step();
      @(negedge clk);
      chk("rst2_valid", 32'(resp_valid), 32'd0);
      chk("rst2_ready", 32'(req_ready), 32'd1);
      step();
      reset     = 1'b0;
      req_valid = 1'b0;
      repeat (4) step();

      // Low-half, high-half with odd checked address, top of address space.
      req(32'h102);
      imem_addr = 32'h0FF;
      req(32'h0FC);
      imem_addr = 32'hFFFF_FFFE;
      req(32'hFFFF_FFFC);
      drain();

      // Miss: fill changes after acceptance must not leak into the stored word.
      imem_addr = 32'h100;
      req(32'h200);
      fill_data = 32'h0;
      drain();
      fill_data = 32'h1234_5678;

      // Back-pressure: four fill the queue, the fifth waits for the first pop.
      resp_ready = 1'b0;
      fork
         begin
            req(32'h0);
            req(32'h4);
            req(32'h8);
            req(32'hC);
            req(32'h10);
         end
         begin
            repeat (8) step();
            @(negedge clk);
            chk("full_ready", 32'(req_ready), 32'd0);
            @(posedge clk);
            #1;
            resp_ready = 1'b1;
         end
      join
      drain();

      // Reset with three entries outstanding.
      resp_ready = 1'b0;
      req(32'h20);
      req(32'h24);
      req(32'h28);
      reset = 1'b1;
      step();
      reset = 1'b0;
      @(negedge clk);
      chk("midrst_valid", 32'(resp_valid), 32'd0);
      chk("midrst_ready", 32'(req_ready), 32'd1);
      step();
      resp_ready = 1'b1;
      repeat (6) step();

`ifdef RVFI_IMEM_RESP_ERR_EN
      fill_err  = 1'b1;
      imem_addr = 32'h100;
      req(32'h100);
      req(32'h200);
      drain();
      fill_err = 1'b0;
`endif

      // Randomized traffic around a moving checked address, with occasional resets.
      base = 32'h1000;
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 7) == 0)
            base = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFF0);
         reset      = ($urandom_range(0, 199) == 0);
         req_valid  = ($urandom_range(0, 2) != 0);
         resp_ready = ($urandom_range(0, 3) != 0);
         req_addr   = base + 32'($urandom_range(0, 15));
         imem_addr  = base + 32'($urandom_range(0, 15));
         imem_data  = 16'($urandom);
         fill_data  = $urandom;
`ifdef RVFI_IMEM_RESP_ERR_EN
         fill_err   = 1'($urandom);
`endif
         step();
      end
      reset      = 1'b0;
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rvfi_imem_resp.md
# rvfi_imem_resp

Formal/simulation instruction-memory responder for the core's fetch port; the driving-side counterpart of the RVFI imem consistency check. Accepts fetch requests and returns 32-bit fetch words after a fixed latency. A fetch word covering the checked halfword address `imem_addr` returns `imem_data` in that halfword. Every other halfword comes from the free `fill_data` input, which the formal wrapper drives with an unconstrained value. It sits between the core wrapper's fetch bus and the checker, so retired instructions can be proven against the same constrained memory word.

## Interface
- `XLEN`, default 32: address width.
- `LATENCY`, default 1: accept-to-response latency in cycles; legal range 1..8.
- `DEPTH`, default 4: maximum outstanding requests; power of two, at least 2.

- `clk` input 1: clock; all logic on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `req_valid` input 1: fetch request valid.
- `req_ready` output 1: request accepted when `req_valid && req_ready` at the clock edge.
- `req_addr` input XLEN: fetch byte address; bits [1:0] ignored.
- `resp_valid` output 1: response valid.
- `resp_ready` input 1: response consumed when `resp_valid && resp_ready` at the clock edge.
- `resp_data` output 32: fetch word.
- `imem_addr` input XLEN: checked halfword address; bit 0 is ignored (treated as 0).
- `imem_data` input 16: checked halfword value.
- `fill_data` input 32: arbitrary fill word, sampled at request acceptance.

## Operation
- On acceptance, let `a = {req_addr[XLEN-1:2], 2'b00}` and `m = {imem_addr[XLEN-1:1], 1'b0}`.
- Stored low half: `imem_data` if `m == a`, else `fill_data[15:0]`.
- Stored high half: `imem_data` if `m == a+2` (modulo 2^XLEN), else `fill_data[31:16]`.
- Both halves are computed at acceptance and stored in an in-order FIFO of `DEPTH` entries. Later changes to `imem_data` or `fill_data` do not affect stored entries.
- Each entry carries an age counter:
  - Loaded with `LATENCY-1` on enqueue.
  - Decrements every cycle while nonzero, including while the entry is not at the head.
  - The head is eligible when its counter is 0.
- `resp_valid` = FIFO non-empty and head eligible. `resp_data` = head data.
- `req_ready` = occupancy < `DEPTH`. There is no full-bypass: a pop in the same cycle does not raise `req_ready` in that cycle.
- Simultaneous push and pop: occupancy unchanged; pointers wrap modulo `DEPTH`.
- Responses are returned strictly in request order.

## Timing
- Reset values: `resp_valid`=0, `resp_data`=0, `req_ready`=1, occupancy 0, all age counters 0.
- Reset asserted mid-operation:
  - All outstanding entries are dropped.
  - `resp_valid`=0 in the cycle after the reset edge.
  - No stale response appears after reset is released.
- For a request accepted at edge t into an otherwise idle block, `resp_valid` rises immediately after edge t+LATENCY-1. For example, with LATENCY=1 the response is visible in the cycle right after the accepting edge.
- While `resp_valid && !resp_ready`, `resp_valid` and `resp_data` stay stable.
- Back-to-back acceptance is allowed every cycle while not full; the response throughput is one per cycle.
- `resp_data` is a registered FIFO read with no combinational path from any input to any output. Exception: `req_ready` depends only on the occupancy register.

## Configuration
- `RVFI_IMEM_RESP_ERR_EN` defined:
  - Adds input `fill_err` (1 bit, sampled at acceptance) and output `resp_err` (1 bit, reset 0, qualified by `resp_valid`, stable under back-pressure).
  - The stored error bit is `fill_err && !(m == a || m == a+2)`. A fetch covering the checked halfword therefore never faults.
- Not defined: neither port exists, and every response is non-faulting.

## Test plan
- Reset: assert `reset` for 2 cycles with `req_valid`=1 -> `resp_valid`=0, `req_ready`=1, nothing accepted; the first post-reset request is answered normally.
- Low-half match: `imem_addr`=0x100, `imem_data`=0xABCD, `fill_data`=0x12345678, request 0x102 -> `resp_data`=0x1234ABCD exactly LATENCY cycles later.
- High-half match with odd-address masking: `imem_addr`=0x0FF, request 0x0FC -> `resp_data`=0xABCD5678. Top-of-space case: `imem_addr`=0xFFFFFFFE, request 0xFFFFFFFC -> 0xABCD5678.
- Miss and sampling: request 0x200, then change `fill_data` to 0 before the response -> `resp_data`=0x12345678.
- Back-pressure (`DEPTH`=4, `resp_ready`=0, 5 consecutive requests 0x0, 0x4, 0x8, 0xC, 0x10):
  - 4 are accepted and `req_ready`=0; the fifth is held.
  - With `resp_ready`=1, responses appear in order, data stays stable while stalled, and the fifth request is accepted one cycle after the first pop.
- Reset with 3 outstanding entries -> `resp_valid`=0 the next cycle and `req_ready`=1. With `RVFI_IMEM_RESP_ERR_EN`, `fill_err`=1 gives: request 0x100 (match) -> `resp_err`=0; request 0x200 -> `resp_err`=1.
